// File: rtl/tower_command_ctrl.sv
// Player command initiator for the 8-slot tower grid: key edge detection, cursor and
// type selection, build/sell validation, command strobes, occupancy map and gold.
module tower_command_ctrl #(
  parameter int START_GOLD   = 200,
  parameter int COST_UNIT    = 50,
  parameter int MAX_TYPE     = 3,
  parameter int GOLD_W       = 12,
  parameter int COOLDOWN_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_type,
  input  logic              key_build,
  input  logic              key_sell,
  input  logic              reward_valid,
  input  logic [7:0]        reward_amount,
  output logic              command_tw,
  output logic              build,
  output logic              sell,
  output logic [2:0]        build_location,
  output logic [2:0]        build_type,
  output logic [2:0]        cursor_location,
  output logic [2:0]        sel_type,
  output logic [7:0]        slot_occupied,
  output logic [GOLD_W-1:0] gold,
  output logic              reject,
  output logic [1:0]        fsm_state
);

  localparam int SUM_W = GOLD_W + 2;
  localparam int CD_W  = (COOLDOWN_CYC < 2) ? 1 : $clog2(COOLDOWN_CYC + 1);

  typedef enum logic [1:0] {IDLE, VALIDATE, ISSUE, COOLDOWN} state_t;

  state_t          state, next_state;
  logic [4:0]      key_now, key_q, key_prev, pressed;
  logic            press_left, press_right, press_type, press_build, press_sell;
  logic            op_build, accept;
  logic [2:0]      loc, typ;
  logic [7:0][2:0] slot_type;
  logic [CD_W-1:0] cd_cnt;
  logic [SUM_W-1:0] debit, credit, bonus, gold_sum;
  logic [GOLD_W-1:0] gold_next;

  function automatic logic [GOLD_W-1:0] cost_of(input logic [2:0] t);
    return GOLD_W'(COST_UNIT * int'(t));
  endfunction

  // History resets to 1 so a key held through reset release never counts as a press.
  assign key_now = {key_sell, key_build, key_type, key_right, key_left};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q    <= '1;
      key_prev <= '1;
    end else begin
      key_q    <= key_now;
      key_prev <= key_q;
    end
  end

  assign pressed     = key_q & ~key_prev;
  assign press_left  = pressed[0];
  assign press_right = pressed[1];
  assign press_type  = pressed[2];
  assign press_build = pressed[3];
  assign press_sell  = pressed[4];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cursor_location <= 3'd0;
      sel_type        <= 3'd1;
    end else begin
      if (press_left && !press_right)
        cursor_location <= cursor_location - 3'd1;
      else if (press_right && !press_left)
        cursor_location <= cursor_location + 3'd1;
      if (press_type)
        sel_type <= (sel_type == 3'(MAX_TYPE)) ? 3'd1 : sel_type + 3'd1;
    end
  end

  // Request latch: a lone build or sell press in IDLE captures the operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_build <= 1'b0;
      loc      <= 3'd0;
      typ      <= 3'd0;
    end else if (state == IDLE && (press_build ^ press_sell)) begin
      op_build <= press_build;
      loc      <= cursor_location;
      typ      <= sel_type;
    end
  end

  assign accept = op_build ? (!slot_occupied[loc] && gold >= cost_of(typ))
                           : slot_occupied[loc];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Strobe protocol: command_tw is high for exactly one cycle (ISSUE); build/sell are
  // only meaningful with it, build_location/build_type are stable from that cycle on.
  always_comb begin
    next_state = state;
    command_tw = 1'b0;
    build      = 1'b0;
    sell       = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (press_build && press_sell)     reject     = 1'b1;
        else if (press_build || press_sell) next_state = VALIDATE;
      end
      VALIDATE: begin
        if (accept) begin
          next_state = ISSUE;
        end else begin
          reject     = 1'b1;
          next_state = IDLE;
        end
      end
      ISSUE: begin
        command_tw = 1'b1;
        build      = op_build;
        sell       = !op_build;
        next_state = COOLDOWN;
      end
      COOLDOWN: begin
        if (cd_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cd_cnt <= '0;
    end else if (state == ISSUE) begin
      cd_cnt <= CD_W'(COOLDOWN_CYC - 1);
    end else if (state == COOLDOWN && cd_cnt != '0) begin
      cd_cnt <= cd_cnt - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      build_location <= 3'd0;
      build_type     <= 3'd0;
    end else if (state == VALIDATE && accept) begin
      build_location <= loc;
      build_type     <= op_build ? typ : slot_type[loc];
    end
  end

  // Debit, credit and any reward land in one combined, saturated update.
  always_comb begin
    debit  = (state == ISSUE && op_build)  ? SUM_W'(cost_of(typ)) : '0;
    credit = (state == ISSUE && !op_build) ? SUM_W'(cost_of(slot_type[loc]) >> 1) : '0;
    bonus  = reward_valid ? SUM_W'(reward_amount) : '0;
    gold_sum = SUM_W'(gold) - debit + credit + bonus;
    if (gold_sum[SUM_W-1])
      gold_next = '0;
    else if (gold_sum[SUM_W-2:GOLD_W] != '0)
      gold_next = '1;
    else
      gold_next = gold_sum[GOLD_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gold          <= GOLD_W'(START_GOLD);
      slot_occupied <= 8'h00;
      slot_type     <= '0;
    end else begin
      gold <= gold_next;
      if (state == ISSUE) begin
        if (op_build) begin
          slot_occupied[loc] <= 1'b1;
          slot_type[loc]     <= typ;
        end else begin
          slot_occupied[loc] <= 1'b0;
          slot_type[loc]     <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tower_command_ctrl.sv
// Directed bench for tower_command_ctrl: one task per scenario, hand-computed expectations.
module tb_tower_command_ctrl;

  localparam logic [4:0] K_LEFT  = 5'b00001;
  localparam logic [4:0] K_RIGHT = 5'b00010;
  localparam logic [4:0] K_TYPE  = 5'b00100;
  localparam logic [4:0] K_BUILD = 5'b01000;
  localparam logic [4:0] K_SELL  = 5'b10000;

  logic        Clk, Reset;
  logic [4:0]  keys;
  logic        reward_valid;
  logic [7:0]  reward_amount;
  logic        command_tw, build, sell, reject;
  logic [2:0]  build_location, build_type, cursor_location, sel_type;
  logic [7:0]  slot_occupied;
  logic [11:0] gold;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int cmd_count = 0;
  int rej_count = 0;
  int c0, r0;

  tower_command_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .key_left(keys[0]), .key_right(keys[1]), .key_type(keys[2]),
    .key_build(keys[3]), .key_sell(keys[4]),
    .reward_valid(reward_valid), .reward_amount(reward_amount),
    .command_tw(command_tw), .build(build), .sell(sell),
    .build_location(build_location), .build_type(build_type),
    .cursor_location(cursor_location), .sel_type(sel_type),
    .slot_occupied(slot_occupied), .gold(gold), .reject(reject),
    .fsm_state(fsm_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (command_tw === 1'b1) cmd_count++;
    if (reject === 1'b1) rej_count++;
    if (Reset === 1'b0 && command_tw === 1'b0) begin
      vectors++;
      if (build !== 1'b0 || sell !== 1'b0) begin
        miscompares++;
        $display("FAIL qualifier_idle: build=%b sell=%b want 0 0", build, sell);
      end
    end
  end

  task automatic do_reset(input logic [4:0] held);
    keys = held;
    reward_valid = 1'b0;
    reward_amount = 8'd0;
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic tap(input logic [4:0] k);
    keys = k;
    @(negedge Clk);
    keys = 5'b0;
    @(negedge Clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset(5'b0);
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    vectors++; if (cursor_location !== 3'd0) begin miscompares++; $display("FAIL reset_cursor: got %0d want 0", cursor_location); end
    vectors++; if (sel_type !== 3'd1) begin miscompares++; $display("FAIL reset_type: got %0d want 1", sel_type); end
    vectors++; if (gold !== 12'd200) begin miscompares++; $display("FAIL reset_gold: got %0d want 200", gold); end
    vectors++; if (slot_occupied !== 8'h00) begin miscompares++; $display("FAIL reset_occ: got %h want 00", slot_occupied); end
    vectors++; if ({command_tw, reject, build_location, build_type} !== 8'h00) begin
      miscompares++; $display("FAIL reset_outs: got %b want 0", {command_tw, reject, build_location, build_type}); end
    // key_build held through reset release must not issue anything
    c0 = cmd_count; r0 = rej_count;
    do_reset(K_BUILD);
    repeat (6) @(negedge Clk);
    keys = 5'b0;
    settle();
    vectors++; if (cmd_count - c0 !== 0) begin miscompares++; $display("FAIL held_build_cmd: got %0d want 0", cmd_count - c0); end
    vectors++; if (rej_count - r0 !== 0) begin miscompares++; $display("FAIL held_build_rej: got %0d want 0", rej_count - r0); end
  endtask

  task automatic test_build();
    do_reset(5'b0);
    c0 = cmd_count;
    tap(K_BUILD);
    vectors++; if (fsm_state !== 2'd1) begin miscompares++; $display("FAIL build_validate: got %0d want 1", fsm_state); end
    @(negedge Clk);
    vectors++; if ({command_tw, build, sell} !== 3'b110) begin miscompares++; $display("FAIL build_strobe: got %b want 110", {command_tw, build, sell}); end
    vectors++; if (build_location !== 3'd0 || build_type !== 3'd1) begin
      miscompares++; $display("FAIL build_loc_type: got %0d/%0d want 0/1", build_location, build_type); end
    @(negedge Clk);
    vectors++; if (command_tw !== 1'b0) begin miscompares++; $display("FAIL build_one_cycle: got %b want 0", command_tw); end
    vectors++; if (gold !== 12'd150) begin miscompares++; $display("FAIL build_gold: got %0d want 150", gold); end
    vectors++; if (slot_occupied !== 8'h01) begin miscompares++; $display("FAIL build_occ: got %h want 01", slot_occupied); end
    vectors++; if (fsm_state !== 2'd3) begin miscompares++; $display("FAIL build_cooldown: got %0d want 3", fsm_state); end
    settle();
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL build_idle: got %0d want 0", fsm_state); end
    vectors++; if (cmd_count - c0 !== 1) begin miscompares++; $display("FAIL build_cmd_count: got %0d want 1", cmd_count - c0); end
  endtask

  task automatic test_occupied_reject();
    c0 = cmd_count;
    tap(K_BUILD);
    vectors++; if (reject !== 1'b1) begin miscompares++; $display("FAIL occ_reject: got %b want 1", reject); end
    @(negedge Clk);
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL occ_reject_idle: got %0d want 0", fsm_state); end
    settle();
    vectors++; if (gold !== 12'd150) begin miscompares++; $display("FAIL occ_reject_gold: got %0d want 150", gold); end
    vectors++; if (cmd_count - c0 !== 0) begin miscompares++; $display("FAIL occ_reject_cmd: got %0d want 0", cmd_count - c0); end
  endtask

  task automatic test_sell();
    tap(K_SELL);
    @(negedge Clk);
    vectors++; if ({command_tw, build, sell} !== 3'b101) begin miscompares++; $display("FAIL sell_strobe: got %b want 101", {command_tw, build, sell}); end
    vectors++; if (build_location !== 3'd0 || build_type !== 3'd1) begin
      miscompares++; $display("FAIL sell_loc_type: got %0d/%0d want 0/1", build_location, build_type); end
    @(negedge Clk);
    vectors++; if (gold !== 12'd175) begin miscompares++; $display("FAIL sell_gold: got %0d want 175", gold); end
    vectors++; if (slot_occupied !== 8'h00) begin miscompares++; $display("FAIL sell_occ: got %h want 00", slot_occupied); end
    settle();
    c0 = cmd_count;
    tap(K_SELL);
    vectors++; if (reject !== 1'b1) begin miscompares++; $display("FAIL sell_empty_reject: got %b want 1", reject); end
    settle();
    vectors++; if (cmd_count - c0 !== 0 || gold !== 12'd175) begin
      miscompares++; $display("FAIL sell_empty_effect: cmds %0d gold %0d want 0 175", cmd_count - c0, gold); end
  endtask

  task automatic test_cost_reject();
    do_reset(5'b0);
    tap(K_TYPE);
    vectors++; if (sel_type !== 3'd2) begin miscompares++; $display("FAIL cost_type2: got %0d want 2", sel_type); end
    tap(K_BUILD);
    @(negedge Clk);
    vectors++; if (build_type !== 3'd2) begin miscompares++; $display("FAIL cost_build_type: got %0d want 2", build_type); end
    @(negedge Clk);
    vectors++; if (gold !== 12'd100) begin miscompares++; $display("FAIL cost_gold100: got %0d want 100", gold); end
    settle();
    tap(K_RIGHT);
    tap(K_TYPE);
    c0 = cmd_count;
    tap(K_BUILD);
    vectors++; if (reject !== 1'b1) begin miscompares++; $display("FAIL cost_reject: got %b want 1", reject); end
    settle();
    vectors++; if (gold !== 12'd100 || slot_occupied !== 8'h01 || cmd_count - c0 !== 0) begin
      miscompares++; $display("FAIL cost_reject_effect: gold %0d occ %h cmds %0d want 100 01 0", gold, slot_occupied, cmd_count - c0); end
  endtask

  task automatic test_cursor_type();
    do_reset(5'b0);
    tap(K_LEFT);
    vectors++; if (cursor_location !== 3'd7) begin miscompares++; $display("FAIL cursor_wrap_left: got %0d want 7", cursor_location); end
    tap(K_RIGHT);
    vectors++; if (cursor_location !== 3'd0) begin miscompares++; $display("FAIL cursor_wrap_right: got %0d want 0", cursor_location); end
    tap(K_LEFT | K_RIGHT);
    vectors++; if (cursor_location !== 3'd0) begin miscompares++; $display("FAIL cursor_both: got %0d want 0", cursor_location); end
    tap(K_RIGHT);
    vectors++; if (cursor_location !== 3'd1) begin miscompares++; $display("FAIL cursor_right: got %0d want 1", cursor_location); end
    tap(K_TYPE);
    tap(K_TYPE);
    vectors++; if (sel_type !== 3'd3) begin miscompares++; $display("FAIL type_3: got %0d want 3", sel_type); end
    tap(K_TYPE);
    vectors++; if (sel_type !== 3'd1) begin miscompares++; $display("FAIL type_wrap: got %0d want 1", sel_type); end
  endtask

  task automatic test_reward_saturation();
    do_reset(5'b0);
    reward_valid = 1'b1;
    reward_amount = 8'd255;
    repeat (15) @(negedge Clk);
    vectors++; if (gold !== 12'd4025) begin miscompares++; $display("FAIL reward_sum: got %0d want 4025", gold); end
    reward_amount = 8'd60;
    @(negedge Clk);
    vectors++; if (gold !== 12'd4085) begin miscompares++; $display("FAIL reward_near_max: got %0d want 4085", gold); end
    reward_amount = 8'd20;
    @(negedge Clk);
    reward_valid = 1'b0;
    vectors++; if (gold !== 12'd4095) begin miscompares++; $display("FAIL reward_saturate: got %0d want 4095", gold); end
  endtask

  task automatic test_reward_with_build();
    do_reset(5'b0);
    tap(K_BUILD);
    @(negedge Clk);
    vectors++; if (command_tw !== 1'b1) begin miscompares++; $display("FAIL rwb_strobe: got %b want 1", command_tw); end
    reward_valid = 1'b1;
    reward_amount = 8'd30;
    @(negedge Clk);
    reward_valid = 1'b0;
    vectors++; if (gold !== 12'd180) begin miscompares++; $display("FAIL rwb_gold: got %0d want 180", gold); end
    settle();
  endtask

  task automatic test_both_pressed();
    do_reset(5'b0);
    c0 = cmd_count; r0 = rej_count;
    tap(K_BUILD | K_SELL);
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL both_state: got %0d want 0", fsm_state); end
    settle();
    vectors++; if (rej_count - r0 !== 1) begin miscompares++; $display("FAIL both_reject: got %0d want 1", rej_count - r0); end
    vectors++; if (cmd_count - c0 !== 0 || gold !== 12'd200) begin
      miscompares++; $display("FAIL both_effect: cmds %0d gold %0d want 0 200", cmd_count - c0, gold); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset(5'b0);
    tap(K_BUILD);
    @(negedge Clk);
    vectors++; if (command_tw !== 1'b1) begin miscompares++; $display("FAIL rmi_strobe: got %b want 1", command_tw); end
    Reset = 1'b1;
    #1;
    vectors++; if (command_tw !== 1'b0) begin miscompares++; $display("FAIL rmi_cmd_drop: got %b want 0", command_tw); end
    vectors++; if (gold !== 12'd200 || slot_occupied !== 8'h00 || fsm_state !== 2'd0) begin
      miscompares++; $display("FAIL rmi_state: gold %0d occ %h st %0d want 200 00 0", gold, slot_occupied, fsm_state); end
    @(negedge Clk);
    Reset = 1'b0;
    settle();
    vectors++; if (gold !== 12'd200 || slot_occupied !== 8'h00) begin
      miscompares++; $display("FAIL rmi_after: gold %0d occ %h want 200 00", gold, slot_occupied); end
  endtask

  initial begin
    Reset = 1'b1;
    keys = 5'b0;
    reward_valid = 1'b0;
    reward_amount = 8'd0;
    test_reset();
    test_build();
    test_occupied_reject();
    test_sell();
    test_cost_reject();
    test_cursor_type();
    test_reward_saturation();
    test_reward_with_build();
    test_both_pressed();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tower_command_ctrl.md
Name: tower_command_ctrl

Overview:
Player-side command initiator for the tower grid. Turns debounced key levels into cursor movement over the 8 tower slots and tower-type selection. Validates build and sell requests against slot occupancy and the gold balance. Issues single-cycle command_tw build/sell strobes with location and type to the tower array, and keeps the occupancy map and gold counter.

Parameters:
START_GOLD, 200, gold value loaded at reset
COST_UNIT, 50, build cost = COST_UNIT * type; sell refund = cost >> 1
MAX_TYPE, 3, highest selectable tower type (types 1..MAX_TYPE; 0 = none)
GOLD_W, 12, gold counter width; saturates at 2^GOLD_W-1
COOLDOWN_CYC, 2, idle cycles after each issued command (min 1)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
key_left  in  1  level, already synchronized; rising edge moves cursor -1
key_right  in  1  rising edge moves cursor +1
key_type  in  1  rising edge advances selected type
key_build  in  1  rising edge requests build at cursor
key_sell  in  1  rising edge requests sell at cursor
reward_valid  in  1  one-cycle kill-reward strobe
reward_amount  in  8  gold added when reward_valid
command_tw  out  1  command strobe to tower array
build  out  1  build qualifier, valid with command_tw
sell  out  1  sell qualifier, valid with command_tw
build_location  out  3  slot index of command
build_type  out  3  tower type of build command
cursor_location  out  3  current cursor slot
sel_type  out  3  currently selected type
slot_occupied  out  8  bit i = slot i holds a tower
gold  out  GOLD_W  current balance
reject  out  1  one-cycle pulse on refused request

Behaviour:
- Reset (async): state IDLE; cursor 0; sel_type 1; gold START_GOLD; slot_occupied 0; per-slot type memory 0; command_tw, build, sell, reject, build_location, build_type = 0. Edge-detect history registers reset to 1, so a key held through reset release is not a press.
- Edge detect: a press is key=1 while the registered previous value is 0. Exactly one event per press.
- Cursor: left/right presses are honoured in every state. Left from 0 wraps to 7; right from 7 wraps to 0. A simultaneous left and right press leaves the cursor unchanged.
- Type: a key_type press cycles sel_type 1->2->..->MAX_TYPE->1.
- FSM states IDLE, VALIDATE, ISSUE, COOLDOWN:
  - IDLE, build press only: latch op=build, loc=cursor, typ=sel_type; go to VALIDATE.
  - IDLE, sell press only: latch op=sell, loc=cursor; go to VALIDATE.
  - IDLE, build and sell pressed together: reject=1 for that cycle; stay in IDLE.
  - Build/sell presses outside IDLE are dropped without reject.
  - VALIDATE, build: accept iff slot_occupied[loc]=0 and gold >= COST_UNIT*typ. Sell: accept iff slot_occupied[loc]=1. Accept goes to ISSUE; otherwise pulse reject one cycle and return to IDLE.
  - ISSUE: command_tw=1 for exactly one cycle, with build/sell, build_location=loc and build_type (typ for build, stored slot type for sell). In the same cycle:
    - build: set occupied[loc], store typ, gold -= cost.
    - sell: clear occupied[loc], gold += stored cost >> 1, stored type <= 0.
    Then go to COOLDOWN.
  - COOLDOWN: command_tw=0 for COOLDOWN_CYC cycles, so the tower array clears its enable and sell arrays; then IDLE.
- Latency: press sampled at edge n -> VALIDATE after edge n+1 -> command_tw high between edges n+2 and n+3. Next command possible no earlier than COOLDOWN_CYC+3 cycles later.
- Qualifier outputs: build and sell are 0 whenever command_tw=0. build_location and build_type hold their last values.
- Gold arithmetic: computed at GOLD_W+2 bits as gold - debit + credit + (reward_valid ? reward_amount : 0), then saturated to [0, 2^GOLD_W-1]. A reward in the same cycle as an ISSUE is applied together with it, never lost. The VALIDATE check uses the registered gold and ignores a same-cycle reward.
- Reset mid-operation (any state, including ISSUE): immediate return to reset values; no partial command completes.

Test Plan:
- Reset; cursor 0, sel_type 1; press key_build -> 2 cycles later one-cycle command_tw=1, build=1, build_location=0, build_type=1; gold 200->150; slot_occupied=8'h01.
- Press build again at slot 0 -> reject pulse, no command_tw, gold stays 150. Set type 3 with gold 100 and build at slot 1 -> reject, since cost 150 > 100.
- Sell slot 0 (type 1) -> command_tw=1, sell=1, build_location=0; gold 150->175; slot_occupied bit0=0. Sell an empty slot -> reject.
- Cursor: left at 0 -> 7; right at 7 -> 0. Type cycles 1,2,3,1. key_build held across reset release -> no command.
- Gold near 4095 plus reward_amount 20 -> 4095 (saturated). A reward of 30 coincident with a 50-cost build from 200 -> 180. Build and sell pressed in the same cycle -> reject, no command.
- Assert Reset during ISSUE -> command_tw drops immediately; gold=200, slot_occupied=0, state IDLE.
